// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Package     : fifo_rd_pkg
// Description : Shared types and constants for the FIFO burst reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

  // Reader control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Entries in the output skid buffer
  localparam int SKID_DEPTH = 2;

  // Width of a counter holding 0..n-1 (at least one bit)
  function automatic int beat_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// ============================================================================
// Module      : fifo_rd_skid
// Description : Two-entry registered skid buffer. Entry 0 is always the head,
//               so the head word is available directly from a register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_occ
);

  localparam logic [1:0] c_FULL = 2'(SKID_DEPTH);

  logic [WIDTH-1:0] r_e0;
  logic [WIDTH-1:0] r_e1;
  logic [1:0]       r_occ;
  logic             w_wr;
  logic             w_rd;

  // Strobes are qualified so a misbehaving caller cannot corrupt occupancy
  assign w_wr = i_wr & (r_occ != c_FULL);
  assign w_rd = i_rd & (r_occ != 2'd0);

  // Shift-style storage: reads move entry 1 into the head slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({w_wr, w_rd})
        2'b10: begin
          if (r_occ == 2'd0) r_e0 <= i_wr_data;
          else               r_e1 <= i_wr_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; new word lands behind whatever remains
          if (r_occ == 2'd1) begin
            r_e0 <= i_wr_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= i_wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_e0;
  assign o_occ  = r_occ;

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ============================================================================
// Module      : fifo_burst_reader
// Description : Pop-side consumer for a show-ahead FIFO. Pops words into a
//               2-entry skid buffer and forwards them on a valid/ready stream,
//               marking every BURST_LEN-th beat with m_last.
//               Optional build macro FIFO_RD_STATS_EN adds a 32-bit count of
//               pop strobes on port words_popped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pndng,
  input  logic [WIDTH-1:0] dato_out,
  output logic             pop,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]      words_popped
`endif
);

  localparam int              c_BW        = beat_width(BURST_LEN);
  localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(BURST_LEN - 1);
  localparam logic [1:0]      c_FULL      = 2'(SKID_DEPTH);

  rd_state_t       r_state;
  logic [c_BW-1:0] r_beat;
  logic [1:0]      w_occ;
  logic [1:0]      w_occ_next;
  logic            w_hs;

  assign w_hs       = m_valid & m_ready;
  assign pop        = pndng & (r_state == RUN) & (w_occ < c_FULL);
  assign w_occ_next = w_occ + {1'b0, pop} - {1'b0, w_hs};
  assign m_valid    = (w_occ != 2'd0);
  assign m_last     = m_valid & (r_beat == c_LAST_BEAT);
  assign busy       = (r_state != IDLE) | m_valid;

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_wr      (pop),
    .i_wr_data (dato_out),
    .i_rd      (w_hs),
    .o_head    (m_data),
    .o_occ     (w_occ)
  );

  // Control FSM: DRAIN lets buffered words leave before going idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (en) r_state <= RUN;
        RUN:     if (!en) r_state <= DRAIN;
        DRAIN: begin
          if (en)                                       r_state <= RUN;
          else if ((w_occ == 2'd0) && (w_occ_next == 2'd0)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat position within the burst; kept across idle so bursts stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
    end else if (w_hs) begin
      r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + c_BW'(1);
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] r_words_popped;

  // Free-running pop counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst)      r_words_popped <= '0;
    else if (pop) r_words_popped <= r_words_popped + 32'd1;
  end

  assign words_popped = r_words_popped;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader with a queue-based
//               FIFO, a queue-based reader model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

  localparam int W  = 16;
  localparam int BL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         m_ready = 1'b0;
  logic         pndng = 1'b0;
  logic [W-1:0] dato_out = '0;
  logic         pop;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic         busy;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]  words_popped;
`endif

  fifo_burst_reader #(.WIDTH(W), .BURST_LEN(BL)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pndng    (pndng),
    .dato_out (dato_out),
    .pop      (pop),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_popped (words_popped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- external FIFO (show-ahead) ----------------
  logic [W-1:0] fifo_q[$];

  // ---------------- reader model ----------------
  int           m_st = 0;          // 0 idle, 1 run, 2 drain
  int           m_beat = 0;
  logic [W-1:0] m_buf[$];
  int unsigned  m_count = 0;
  int           occ, occn;

  // values sampled mid-cycle, consumed at the following edge
  logic         s_pop = 1'b0, s_hs = 1'b0, s_en = 1'b0, s_rst = 1'b1;
  logic         s_dpop = 1'b0, s_dvalid = 1'b0, s_ready = 1'b0, s_last = 1'b0;
  logic [W-1:0] s_word = '0, s_data = '0;
  logic         e_valid, e_pop, e_last, e_busy;

  // observed stream
  logic [W-1:0] recv_d[$];
  logic         recv_l[$];
  int           recv_t[$];
  int           pop_cnt = 0;
  int           cyc_cnt = 0;

  // Compare outputs with model on the falling edge
  always @(negedge clk) begin
    e_valid = (m_buf.size() != 0);
    e_pop   = pndng && (m_st == 1) && (m_buf.size() < 2);
    e_last  = e_valid && (m_beat == BL - 1);
    e_busy  = (m_st != 0) || e_valid;
    check("pop", 32'(pop), 32'(e_pop));
    check("m_valid", 32'(m_valid), 32'(e_valid));
    check("m_last", 32'(m_last), 32'(e_last));
    check("busy", 32'(busy), 32'(e_busy));
    if (e_valid) check("m_data", 32'(m_data), 32'(m_buf[0]));
`ifdef FIFO_RD_STATS_EN
    check("words_popped", words_popped, m_count);
`endif
    s_pop = e_pop; s_hs = e_valid && m_ready; s_word = dato_out;
    s_en = en; s_rst = rst; s_dpop = pop; s_dvalid = m_valid;
    s_ready = m_ready; s_last = m_last; s_data = m_data;
  end

  // Advance the model on the rising edge
  always @(posedge clk) begin
    cyc_cnt++;
    if (s_dpop) pop_cnt++;
    if (s_rst) begin
      m_buf.delete();
      m_st = 0; m_beat = 0; m_count = 0;
    end else begin
      if (s_dvalid && s_ready) begin
        recv_d.push_back(s_data); recv_l.push_back(s_last); recv_t.push_back(cyc_cnt);
      end
      occ  = m_buf.size();
      occn = occ + int'(s_pop) - int'(s_hs);
      if (s_hs) begin
        void'(m_buf.pop_front());
        m_beat = (m_beat + 1) % BL;
      end
      if (s_pop) begin
        m_buf.push_back(s_word);
        m_count++;
      end
      case (m_st)
        0: if (s_en) m_st = 1;
        1: if (!s_en) m_st = 2;
        default: if (s_en) m_st = 1; else if (occ == 0 && occn == 0) m_st = 0;
      endcase
    end
  end

  // FIFO reacts to the DUT pop, then presents its new head
  always @(posedge clk) begin
    #1;
    if (s_dpop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    pndng    = (fifo_q.size() != 0);
    dato_out = pndng ? fifo_q[0] : '0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rb, pb;

  initial begin
    // 1: reset with data pending
    rst = 1'b1; en = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    cyc(2);
    check("t1_pndng", 32'(pndng), 32'd1);
    check("t1_pop", 32'(pop), 32'd0);
    check("t1_valid", 32'(m_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STATS_EN
    check("t1_words_popped", words_popped, 32'd0);
`endif

    // 2: eight preloaded words stream out back to back
    rb = recv_d.size(); pb = pop_cnt;
    rst = 1'b0;
    cyc(20);
    check("t2_count", 32'(recv_d.size() - rb), 32'd8);
    check("t2_pops", 32'(pop_cnt - pb), 32'd8);
    if (recv_d.size() - rb == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_data", 32'(recv_d[rb+i]), 32'(i + 1));
        check("t2_last", 32'(recv_l[rb+i]), 32'((i == 3) || (i == 7)));
      end
      check("t2_rate", 32'(recv_t[rb+7] - recv_t[rb]), 32'd7);
    end

    // 3: back-pressure with five queued words
    rb = recv_d.size(); pb = pop_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(W'(16'h11 + i));
    cyc(10);
    check("t3_pops_held", 32'(pop_cnt - pb), 32'd2);
    check("t3_fifo_left", 32'(fifo_q.size()), 32'd3);
    m_ready = 1'b1;
    cyc(12);
    check("t3_pops_total", 32'(pop_cnt - pb), 32'd5);
    check("t3_count", 32'(recv_d.size() - rb), 32'd5);
    if (recv_d.size() - rb == 5)
      for (int i = 0; i < 5; i++) check("t3_data", 32'(recv_d[rb+i]), 32'(16'h11 + i));

    // filler to bring the burst back to beat 0
    for (int i = 0; i < 3; i++) fifo_q.push_back(W'(16'h31 + i));
    cyc(10);

    // 4: stop with a full buffer, drain, resume with burst alignment kept
    rb = recv_d.size(); pb = pop_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(W'(16'h21 + i));
    cyc(5);
    en = 1'b0; m_ready = 1'b1;
    cyc(6);
    check("t4_pops_stop", 32'(pop_cnt - pb), 32'd2);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_drained", 32'(recv_d.size() - rb), 32'd2);
    en = 1'b1;
    cyc(8);
    check("t4_count", 32'(recv_d.size() - rb), 32'd4);
    if (recv_d.size() - rb == 4)
      for (int i = 0; i < 4; i++) begin
        check("t4_data", 32'(recv_d[rb+i]), 32'(16'h21 + i));
        check("t4_last", 32'(recv_l[rb+i]), 32'(i == 3));
      end

    // 5: reset while the buffer holds two words
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(W'(16'h41 + i));
    cyc(5);
    check("t5_valid_pre", 32'(m_valid), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_last", 32'(m_last), 32'd0);
    rb = recv_d.size();
    m_ready = 1'b1;
    cyc(8);
    check("t5_count", 32'(recv_d.size() - rb), 32'd2);
    if (recv_d.size() - rb == 2) begin
      check("t5_data0", 32'(recv_d[rb]), 32'h43);
      check("t5_data1", 32'(recv_d[rb+1]), 32'h44);
      check("t5_last0", 32'(recv_l[rb]), 32'd0);
    end

    // randomized traffic, model checks every cycle
    for (int c = 0; c < 400; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst     = ($urandom_range(0, 79) == 0);
      if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) fifo_q.push_back(W'($urandom));
      cyc(1);
    end
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    cyc(30);
    check("rand_fifo_empty", 32'(fifo_q.size()), 32'd0);
    check("rand_valid_end", 32'(m_valid), 32'd0);

    // 6: ten pops after reset
    rst = 1'b1;
    cyc(1);
    rst = 1'b0; pb = pop_cnt;
    for (int i = 0; i < 10; i++) fifo_q.push_back(W'(16'h60 + i));
    cyc(20);
    check("t6_pops", 32'(pop_cnt - pb), 32'd10);
`ifdef FIFO_RD_STATS_EN
    check("t6_words_popped", words_popped, 32'd10);
    cyc(5);
    check("t6_words_hold", words_popped, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
